// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order retirement sequencer for the reorder buffer head.
// Each cycle it commits, stalls, holds for a store handshake, or commits and
// broadcasts a flush on a mispredicted branch. Outputs are Mealy-style from
// the current state and the head inputs, and are forced low while rst is low.
// Optional build macro: ROB_COMMIT_PERF_EN enables the stall_count counter.
module rob_commit_ctrl #(
  parameter int ROB_IDX_W    = 5,
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rob_empty,
  input  logic                 head_done,
  input  logic [ROB_IDX_W-1:0] head_idx,
  input  logic [4:0]           head_rd,
  input  logic [DATA_W-1:0]    head_value,
  input  logic                 head_is_store,
  input  logic                 head_is_branch,
  input  logic                 head_mispredict,
  input  logic [DATA_W-1:0]    head_target,
  input  logic                 mem_st_ack,
  output logic                 rob_commit,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [DATA_W-1:0]    rf_data,
  output logic [ROB_IDX_W-1:0] rf_tag,
  output logic                 st_release,
  output logic                 flush,
  output logic [DATA_W-1:0]    flush_pc,
  output logic [31:0]          commit_count,
  output logic [31:0]          stall_count
);

  // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  tgt_q, tgt_d;
  logic               commit_c, st_rel_c, flush_c;
  logic [DATA_W-1:0]  flush_pc_c;
  logic [31:0]        commit_cnt_q;

  // State, flush counter and latched redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state and per-cycle retirement decision for the head entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    commit_c   = 1'b0;
    st_rel_c   = 1'b0;
    flush_c    = 1'b0;
    flush_pc_c = '0;
    case (state_q)
      IDLE: begin
        if (!rob_empty && head_done) begin
          if (head_is_store) begin
            st_rel_c = 1'b1;
            state_d  = STORE_WAIT;
          end else if (head_is_branch && head_mispredict) begin
            commit_c   = 1'b1;
            flush_c    = 1'b1;
            flush_pc_c = head_target;
            tgt_d      = head_target;
            cnt_d      = CNT_LOAD;
            if (FLUSH_CYCLES > 1) state_d = FLUSH;
          end else begin
            commit_c = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        // Release stays asserted through the ack cycle; the pop happens then.
        st_rel_c = 1'b1;
        if (mem_st_ack) begin
          commit_c = 1'b1;
          state_d  = IDLE;
        end
      end
      FLUSH: begin
        // The first flush cycle was spent in IDLE, so leave when the count hits 1.
        flush_c    = 1'b1;
        flush_pc_c = tgt_q;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so they drop asynchronously.
  assign rob_commit = rst & commit_c;
  assign st_release = rst & st_rel_c;
  assign flush      = rst & flush_c;
  assign flush_pc   = rst ? flush_pc_c : '0;
  assign rf_we      = rob_commit & ~head_is_store & (head_rd != 5'd0);
  assign rf_rd      = rob_commit ? head_rd    : '0;
  assign rf_data    = rob_commit ? head_value : '0;
  assign rf_tag     = rob_commit ? head_idx   : '0;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) commit_cnt_q <= '0;
    else if (rob_commit) commit_cnt_q <= commit_cnt_q + 32'd1;
  end
  assign commit_count = commit_cnt_q;

`ifdef ROB_COMMIT_PERF_EN
  logic        stall_c;
  logic [31:0] stall_cnt_q;
  assign stall_c = ((state_q == IDLE) && !rob_empty && !head_done) ||
                   ((state_q == STORE_WAIT) && !mem_st_ack);
  // Counts cycles where a present head could not retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else if (stall_c) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
